// File: rtl/mips_pkg.sv
// Shared MIPS HI/LO unit definitions: funct encodings, sequencer states and
// the default operand width.
package mips_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic is_iter_op(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative magnitude datapath: one shift-add multiply step or one restoring
// shift-subtract divide step per enabled cycle.
module muldiv_datapath
    import mips_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic [XLEN-1:0] o_upper,
    output logic [XLEN-1:0] o_lower
);

    // r_acc: partial product high half / partial remainder; r_q: multiplier / quotient
    logic [XLEN:0]   r_acc;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_m;

    logic [XLEN:0] w_add;
    logic [XLEN:0] w_shl;
    logic [XLEN:0] w_sub;

    always_comb begin
        w_add = r_acc + (r_q[0] ? {1'b0, r_m} : {(XLEN+1){1'b0}});
        w_shl = {r_acc[XLEN-1:0], r_q[XLEN-1]};
        w_sub = w_shl - {1'b0, r_m};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_q   <= '0;
            r_m   <= '0;
        end else if (i_load) begin
            r_acc <= '0;
            r_q   <= i_op_a;
            r_m   <= i_op_b;
        end else if (i_step) begin
            if (i_is_div) begin
                // Top bit of the difference set means the trial subtract went negative: restore
                if (!w_sub[XLEN]) begin
                    r_acc <= w_sub;
                    r_q   <= {r_q[XLEN-2:0], 1'b1};
                end else begin
                    r_acc <= w_shl;
                    r_q   <= {r_q[XLEN-2:0], 1'b0};
                end
            end else begin
                r_acc <= {1'b0, w_add[XLEN:1]};
                r_q   <= {w_add[0], r_q[XLEN-1:1]};
            end
        end
    end

    assign o_upper = r_acc[XLEN-1:0];
    assign o_lower = r_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// MIPS HI/LO unit: sequences iterative mult/div, applies sign correction and
// owns the architectural HI/LO registers plus decode stall.
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [5:0]      funct,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic            div0,
    output logic [XLEN-1:0] rd_data,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_dividend;
    logic            r_is_div;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_div_zero;
    logic            r_busy;
    logic            r_done;

    logic            w_signed;
    logic            w_iter;
    logic            w_neg_a;
    logic            w_neg_b;
    logic            w_load;
    logic            w_step;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN-1:0] w_upper;
    logic [XLEN-1:0] w_lower;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_res_hi;
    logic [XLEN-1:0] w_res_lo;

    always_comb begin
        w_signed = ~funct[0];
        w_iter   = is_iter_op(funct);
        w_neg_a  = w_signed & srcA[XLEN-1];
        w_neg_b  = w_signed & srcB[XLEN-1];
        w_abs_a  = w_neg_a ? -srcA : srcA;
        w_abs_b  = w_neg_b ? -srcB : srcB;
        w_load   = (r_state == ST_IDLE) && start && !flush && w_iter;
        w_step   = (r_state == ST_CALC) && !flush;
    end

    muldiv_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_is_div (r_is_div),
        .i_op_a   (w_abs_a),
        .i_op_b   (w_abs_b),
        .o_upper  (w_upper),
        .o_lower  (w_lower)
    );

    // Signed results are rebuilt from the magnitude result in the FIX cycle
    always_comb begin
        w_prod   = {w_upper, w_lower};
        w_res_hi = '0;
        w_res_lo = '0;
        if (r_is_div) begin
            if (r_div_zero) begin
                w_res_hi = r_dividend;
                w_res_lo = '1;
            end else begin
                w_res_hi = r_neg_r ? -w_upper : w_upper;
                w_res_lo = r_neg_q ? -w_lower : w_lower;
            end
        end else begin
            if (r_neg_q) begin
                w_prod = -w_prod;
            end
            w_res_hi = w_prod[2*XLEN-1:XLEN];
            w_res_lo = w_prod[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_dividend <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        if (w_iter) begin
                            r_state    <= ST_CALC;
                            r_cnt      <= CW'(XLEN - 1);
                            r_busy     <= 1'b1;
                            r_is_div   <= funct[1];
                            r_neg_q    <= w_neg_a ^ w_neg_b;
                            r_neg_r    <= w_neg_a;
                            r_div_zero <= funct[1] && (srcB == '0);
                            r_dividend <= srcA;
                        end else if (funct == FN_MTHI) begin
                            r_hi <= srcA;
                        end else if (funct == FN_MTLO) begin
                            r_lo <= srcA;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (!flush) begin
                        r_hi <= w_res_hi;
                        r_lo <= w_res_lo;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A flush arriving in the FIX cycle suppresses the completion pulse
    assign done    = r_done & ~flush;
    assign div0    = r_done & r_div_zero & ~flush;
    assign busy    = r_busy;
    assign stall   = start & r_busy;
    assign rd_data = (funct == FN_MFHI) ? r_hi : r_lo;
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: expected HI/LO/div0 go into a scoreboard
// queue at issue and are popped when done is seen.
module tb_muldiv_sequencer;
    import mips_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    logic [31:0] arch_hi = 32'h0;
    logic [31:0] arch_lo = 32'h0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .funct   (funct),
        .srcA    (srcA),
        .srcB    (srcB),
        .flush   (flush),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .div0    (div0),
        .rd_data (rd_data),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        logic [63:0] up;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        r = '0;
        case (f)
            FN_MULT: begin
                sp = sa * sb;
                r.hi = sp[63:32];
                r.lo = sp[31:0];
            end
            FN_MULTU: begin
                up = {32'h0, a} * {32'h0, b};
                r.hi = up[63:32];
                r.lo = up[31:0];
            end
            FN_DIV: begin
                if (b == 32'h0) begin
                    r.hi = a; r.lo = 32'hFFFF_FFFF; r.div0 = 1'b1;
                end else begin
                    sp = sa / sb;
                    r.lo = sp[31:0];
                    sp = sa % sb;
                    r.hi = sp[31:0];
                end
            end
            default: begin
                if (b == 32'h0) begin
                    r.hi = a; r.lo = 32'hFFFF_FFFF; r.div0 = 1'b1;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    // Issue one iterative op; optionally hold an mflo in decode from cycle mf_at on.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, input int mf_at);
        exp_t got;
        int   cyc;
        bit   seen;
        sb_q.push_back(e);
        start = 1'b1; funct = f; srcA = a; srcB = b;
        @(negedge clk);
        check("issue_stall", stall, 0);
        check("issue_busy", busy, 0);
        next_cycle();
        start = 1'b0;
        cyc  = 1;
        seen = 0;
        got  = '0;
        while (!seen && cyc < 40) begin
            if (mf_at != 0 && cyc == mf_at) begin
                start = 1'b1; funct = FN_MFLO;
            end
            @(negedge clk);
            if (mf_at != 0 && cyc >= mf_at) check("mflo_stall", stall, 1);
            if (done) begin
                seen = 1;
                check("done_cycle", cyc, 33);
                check("done_busy", busy, 1);
                check("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) got = sb_q.pop_front();
                check("div0", div0, got.div0);
            end else begin
                check("busy_calc", busy, 1);
            end
            next_cycle();
            cyc++;
        end
        check("done_seen", seen, 1);
        @(negedge clk);
        check("hi_result", hi, got.hi);
        check("lo_result", lo, got.lo);
        check("busy_after", busy, 0);
        check("done_after", done, 0);
        if (mf_at != 0) begin
            check("mflo_release", stall, 0);
            check("mflo_rd_data", rd_data, got.lo);
        end
        arch_hi = got.hi;
        arch_lo = got.lo;
        $display("op funct=%b a=%h b=%h -> hi=%h lo=%h div0=%b", f, a, b, hi, lo, div0);
        next_cycle();
        start = 1'b0;
    endtask

    // Start a mult, then abort it in cycle 5 with flush or reset.
    task automatic abort_op(input bit use_rst, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int dones;
        start = 1'b1; funct = FN_MULT; srcA = 32'h0000_0007; srcB = 32'h0000_0009;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c < 5; c++) next_cycle();
        if (use_rst) rst_n = 1'b0;
        else flush = 1'b1;
        @(negedge clk);
        check("abort_no_done", done, 0);
        next_cycle();
        rst_n = 1'b1;
        flush = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        dones = 0;
        for (int c = 0; c < 35; c++) begin
            next_cycle();
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_done_count", dones, 0);
        check("abort_hi", hi, exp_hi);
        check("abort_lo", lo, exp_lo);
        $display("abort %s: hi=%h lo=%h busy=%b", use_rst ? "reset" : "flush", hi, lo, busy);
        next_cycle();
    endtask

    initial begin : stimulus
        logic [5:0] ops [4];
        logic [31:0] ra;
        logic [31:0] rb;
        ops[0] = FN_MULT; ops[1] = FN_MULTU; ops[2] = FN_DIV; ops[3] = FN_DIVU;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct = 6'h0; srcA = '0; srcB = '0;
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_div0", div0, 0);
        $display("reset: hi=%h lo=%h busy=%b", hi, lo, busy);
        next_cycle();
        rst_n = 1'b1;

        start = 1'b1; funct = FN_MTHI; srcA = 32'h1234_5678;
        @(negedge clk);
        check("mthi_busy", busy, 0);
        check("mthi_stall", stall, 0);
        next_cycle();
        funct = FN_MTLO; srcA = 32'h9ABC_DEF0;
        next_cycle();
        funct = FN_MFHI;
        @(negedge clk);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mtlo_lo", lo, 32'h9ABC_DEF0);
        check("mfhi_rd_data", rd_data, 32'h1234_5678);
        next_cycle();
        funct = FN_MFLO;
        @(negedge clk);
        check("mflo_rd_data", rd_data, 32'h9ABC_DEF0);
        $display("mthi/mtlo: hi=%h lo=%h", hi, lo);
        next_cycle();
        arch_hi = 32'h1234_5678;
        arch_lo = 32'h9ABC_DEF0;

        funct = 6'b100000; srcA = 32'hDEAD_BEEF;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        check("nonhilo_busy", busy, 0);
        check("nonhilo_hi", hi, arch_hi);
        check("nonhilo_lo", lo, arch_lo);
        $display("non-hilo funct ignored: busy=%b", busy);
        next_cycle();

        start = 1'b1; flush = 1'b1; funct = FN_MULT; srcA = 32'h3; srcB = 32'h3;
        next_cycle();
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_beats_start", busy, 0);
        $display("flush with start: busy=%b", busy);
        next_cycle();

        run_op(FN_MULT,  32'hFFFF_FFFE, 32'h0000_0003, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA, div0: 1'b0}, 10);
        run_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, div0: 1'b0}, 0);
        run_op(FN_DIV,   32'hFFFF_FFF9, 32'h0000_0002, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, div0: 1'b0}, 0);
        run_op(FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, '{hi: 32'h0000_0000, lo: 32'h8000_0000, div0: 1'b0}, 0);
        run_op(FN_DIVU,  32'h0000_0005, 32'h0000_0000, '{hi: 32'h0000_0005, lo: 32'hFFFF_FFFF, div0: 1'b1}, 0);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = (i >= 2) ? $urandom_range(1, 1000) : $urandom;
            run_op(ops[i], ra, rb, model(ops[i], ra, rb), 0);
        end

        abort_op(1'b0, arch_hi, arch_lo);

        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        abort_op(1'b1, 32'h0, 32'h0);

        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
